// File: rtl/fir_mc_engine_pkg.sv
// Shared types and width helpers for the multi-channel FIR engine.
package fir_mc_package;

    localparam int unsigned LEN_W   = 32;
    localparam int unsigned SHIFT_W = 6;
    localparam int unsigned TOTAL_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fir_state_e;

    typedef struct packed {
        logic               start;
        logic [LEN_W-1:0]   len;
        logic [SHIFT_W-1:0] shift;
    } ctrl_fir_mc_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_fir_mc_t;

    // Accumulator width: full product plus log2(taps) growth bits
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coeff_w,
                                              input int unsigned taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mc_engine_if.sv
// Sample input stream and tagged result output stream of the FIR engine.
interface fir_mc_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_CH       = 2
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                  x_valid_i;
    logic                  x_ready_o;
    logic [DATA_WIDTH-1:0] x_data_i;
    logic                  y_valid_o;
    logic                  y_ready_i;
    logic [DATA_WIDTH-1:0] y_data_o;
    logic [CH_W-1:0]       y_ch_o;

    modport slave (
        input  x_valid_i, x_data_i, y_ready_i,
        output x_ready_o, y_valid_o, y_data_o, y_ch_o
    );

    modport master (
        output x_valid_i, x_data_i, y_ready_i,
        input  x_ready_o, y_valid_o, y_data_o, y_ch_o
    );
endinterface

// File: rtl/fir_mc_engine_mac.sv
// Combinational dot product, arithmetic right shift and signed saturation
// for one channel's delay line.
module fir_mc_mac
    import fir_mc_package::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned N_TAPS      = 8
) (
    input  logic [N_TAPS-1:0][COEFF_WIDTH-1:0] coeff,
    input  logic [N_TAPS-1:0][DATA_WIDTH-1:0]  taps,
    input  logic [SHIFT_W-1:0]                 shift,
    output logic [DATA_WIDTH-1:0]              y_c
);
    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
    localparam int unsigned PROD_W    = DATA_WIDTH + COEFF_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int k = 0; k < int'(N_TAPS); k++) begin
            prod = PROD_W'($signed(coeff[k])) * PROD_W'($signed(taps[k]));
            acc  = acc + ACC_WIDTH'(prod);
        end
    end

    assign shifted = acc >>> shift;

    always_comb begin
        if (shifted > SAT_MAX) begin
            y_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            y_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            y_c = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_mc_engine.sv
// Channel-interleaved FIR filter engine: per-channel delay lines, shared
// coefficient set, one registered result per accepted input sample.
module fir_mc_engine
    import fir_mc_package::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned N_TAPS      = 8,
    parameter int unsigned N_CH        = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       test_mode_i,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [LEN_W-1:0]           len_i,
    input  logic [SHIFT_W-1:0]         shift_i,
    input  logic                       coeff_we_i,
    input  logic [$clog2(N_TAPS)-1:0]  coeff_idx_i,
    input  logic [COEFF_WIDTH-1:0]     coeff_data_i,
    fir_mc_if.slave                    bus,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = 32;

    typedef logic [N_TAPS-1:0][COEFF_WIDTH-1:0]           coeff_t;
    typedef logic [N_TAPS-1:0][DATA_WIDTH-1:0]            taps_t;
    typedef logic [N_CH-1:0][N_TAPS-1:0][DATA_WIDTH-1:0]  dline_t;

    fir_state_e            state_q, state_d;
    coeff_t                coeff_q, coeff_d;
    dline_t                dline_q, dline_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TOTAL_W-1:0]    total_q, total_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic                  y_valid_q, y_valid_d;
    logic [DATA_WIDTH-1:0] y_data_q, y_data_d;
    logic [CH_W-1:0]       y_ch_q, y_ch_d;
    logic                  done_q, done_d;

    ctrl_fir_mc_t          ctrl;
    flags_fir_mc_t         flags;
    taps_t                 taps_new;
    logic [DATA_WIDTH-1:0] mac_y_c;
    logic                  x_ready;
    logic                  hs;
    logic                  last_sample;
    logic                  unused_test_mode;

    assign unused_test_mode = test_mode_i;
    assign ctrl = '{start: start_i, len: len_i, shift: shift_i};

    // New sample enters tap 0 of the current channel's line
    assign taps_new    = {dline_q[ptr_q][N_TAPS-2:0], bus.x_data_i};
    assign x_ready     = (state_q == ST_RUN) && (!y_valid_q || bus.y_ready_i);
    assign hs          = bus.x_valid_i && x_ready;
    assign last_sample = (TOTAL_W'(cnt_q) + TOTAL_W'(1)) == total_q;

    fir_mc_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .N_TAPS      (N_TAPS)
    ) u_mac (
        .coeff (coeff_q),
        .taps  (taps_new),
        .shift (shift_q),
        .y_c   (mac_y_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        coeff_d   = coeff_q;
        dline_d   = dline_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        shift_d   = shift_q;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_ch_d    = y_ch_q;
        done_d    = 1'b0;

        if (y_valid_q && bus.y_ready_i) begin
            y_valid_d = 1'b0;
        end

        if (hs) begin
            y_valid_d      = 1'b1;
            y_data_d       = mac_y_c;
            y_ch_d         = ptr_q;
            dline_d[ptr_q] = taps_new;
            ptr_d          = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + CH_W'(1);
            cnt_d          = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (coeff_we_i) begin
                    coeff_d[coeff_idx_i] = coeff_data_i;
                end
                if (ctrl.start) begin
                    if (ctrl.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        dline_d = '0;
                        ptr_d   = '0;
                        cnt_d   = '0;
                        total_d = TOTAL_W'(ctrl.len) * TOTAL_W'(N_CH);
                        shift_d = ctrl.shift;
                    end
                end
            end
            ST_RUN: begin
                if (hs && last_sample) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Done once the last result leaves (or has left) the output register
                if (!y_valid_q || bus.y_ready_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d   = ST_IDLE;
            dline_d   = '0;
            ptr_d     = '0;
            cnt_d     = '0;
            y_valid_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            coeff_q   <= '0;
            dline_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            total_q   <= '0;
            shift_q   <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_ch_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            coeff_q   <= coeff_d;
            dline_q   <= dline_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            shift_q   <= shift_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_ch_q    <= y_ch_d;
            done_q    <= done_d;
        end
    end

    assign flags = '{busy: (state_q != ST_IDLE), done: done_q};

    assign bus.x_ready_o = x_ready;
    assign bus.y_valid_o = y_valid_q;
    assign bus.y_data_o  = y_data_q;
    assign bus.y_ch_o    = y_ch_q;
    assign busy_o        = flags.busy;
    assign done_o        = flags.done;

endmodule
